// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divider
// computation, so the receiver and transmitter derive identical timing.
package uart_rx_pkg;

    // Receiver FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_DATA      = ST_DATA,
        S_STOP      = ST_STOP,
        S_WAIT_IDLE = ST_WAIT_IDLE
    } rx_state_e;

    // Clocks per sample tick, floored.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    // 2-of-3 majority.
    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: one-clock tick every DIV clocks.
module baud_tick_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the last count, then wrap to zero.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Divider counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start detection,
// 3-sample majority vote per bit, LSB-first shift register, one-clock
// o_valid / o_frame_err pulses.
//
// Sample counter alignment: the counter is cleared on the tick where the
// start-bit centre is confirmed. From there every bit is OVERSAMPLE ticks
// long and the counter value seen at a tick is (ticks since centre - 1),
// so OVERSAMPLE-2 / OVERSAMPLE-1 / OVERSAMPLE are the samples one tick
// before, at, and one tick after each bit centre. The bit is decided on
// the last of the three; the counter then restarts at 1 to keep the
// OVERSAMPLE-tick bit period.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned PAYLOAD_SIZE = 8,
    parameter int unsigned OVERSAMPLE   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx,
    output logic [PAYLOAD_SIZE-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_frame_err
);

    localparam int unsigned SCW = $clog2(OVERSAMPLE + 1);
    localparam int unsigned BCW = $clog2(PAYLOAD_SIZE + 1);

    localparam logic [SCW-1:0] S_HALF = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] S_PRE  = SCW'(OVERSAMPLE - 2);
    localparam logic [SCW-1:0] S_MID  = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_POST = SCW'(OVERSAMPLE);
    localparam logic [BCW-1:0] B_LAST = BCW'(PAYLOAD_SIZE - 1);

    logic                    tick;
    logic [1:0]              sync_q, sync_d;
    logic                    line;
    rx_state_e               state_q, state_d;
    logic [SCW-1:0]          samp_q, samp_d;
    logic [BCW-1:0]          bit_q, bit_d;
    logic [PAYLOAD_SIZE-1:0] shift_q, shift_d;
    logic [1:0]              votes_q, votes_d;
    logic [PAYLOAD_SIZE-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    bit_val;

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .tick (tick)
    );

    // Synchronizer shift; line is the metastability-safe copy of i_rx.
    always_comb begin
        sync_d = {sync_q[0], i_rx};
        line   = sync_q[1];
    end

    // Next-state, sampling, shift register and output pulse logic.
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        votes_d = votes_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        bit_val = vote3(votes_q[0], votes_q[1], line);

        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!line) begin
                        state_d = S_START;
                        samp_d  = '0;
                    end
                end

                S_START: begin
                    if (samp_q == S_HALF) begin
                        samp_d = '0;
                        if (!line) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            // Too short to be a start bit
                            state_d = S_IDLE;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (samp_q == S_PRE) votes_d[0] = line;
                    if (samp_q == S_MID) votes_d[1] = line;
                    if (samp_q == S_POST) begin
                        shift_d                 = shift_q >> 1;
                        shift_d[PAYLOAD_SIZE-1] = bit_val;
                        samp_d                  = SCW'(1);
                        if (bit_q == B_LAST) begin
                            state_d = S_STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (samp_q == S_PRE) votes_d[0] = line;
                    if (samp_q == S_MID) votes_d[1] = line;
                    if (samp_q == S_POST) begin
                        samp_d = '0;
                        if (bit_val) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    // Need a full bit of consecutive high ticks (ends a break)
                    if (line) begin
                        if (samp_q == S_MID) begin
                            state_d = S_IDLE;
                            samp_d  = '0;
                        end else begin
                            samp_d = samp_q + 1'b1;
                        end
                    end else begin
                        samp_d = '0;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    samp_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            votes_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            votes_q <= votes_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames checked
// against an expected-event list built from the frame contents.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CLK_FREQ = 768000;               // 5 clocks per tick at 9600x16
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIVV     = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = CLK_FREQ / BAUD;       // clocks per bit
    localparam int LAT_MIN  = 9 * BIT + BIT / 2;
    localparam int LAT_MAX  = LAT_MIN + BIT / 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    uart_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD),
        .PAYLOAD_SIZE(8),
        .OVERSAMPLE  (OS)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err)
    );

    // Event log: kind 1 = valid, 2 = frame error
    int         ev_kind[$];
    logic [7:0] ev_data[$];
    int         ev_cyc[$];
    int         cyc      = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_v   = 1'b0;
    logic       prev_e   = 1'b0;

    always @(negedge i_clk) begin
        cyc <= cyc + 1;
        if (o_valid) begin
            ev_kind.push_back(1);
            ev_data.push_back(o_data);
            ev_cyc.push_back(cyc);
        end
        if (o_frame_err) begin
            ev_kind.push_back(2);
            ev_data.push_back(o_data);
            ev_cyc.push_back(cyc);
        end
        if (o_valid && o_frame_err) both_cnt <= both_cnt + 1;
        if ((o_valid && prev_v) || (o_frame_err && prev_e)) wide_cnt <= wide_cnt + 1;
        prev_v <= o_valid;
        prev_e <= o_frame_err;
    end

    int         tx_start_cyc;
    logic [7:0] last_good = 8'h00;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // One bit period; flip inverts a single tick-wide window at the centre
    task automatic drive_bit(input logic val, input logic flip);
        for (int c = 0; c < BIT; c++) begin
            i_rx = val ^ (flip && c >= BIT / 2 - DIVV / 2 && c < BIT / 2 - DIVV / 2 + DIVV);
            @(negedge i_clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic flip);
        tx_start_cyc = cyc;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], flip);
        drive_bit(stop_val, 1'b0);
        i_rx = 1'b1;
    endtask

    task automatic test_reset();
        wait_clks(3);
        checks++;
        if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
        checks++;
        if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got v=%b e=%b want 0 0", o_valid, o_frame_err);
        end
        checks++;
        if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        i_rst = 1'b0;
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() != 0) begin errors++; $display("FAIL idle_quiet: got %0d events want 0", ev_kind.size()); end
    endtask

    task automatic test_single();
        int mark;
        int lat;
        mark = ev_kind.size();
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != 1) begin
            errors++; $display("FAIL a5_count: got %0d events want 1", ev_kind.size() - mark);
        end else begin
            checks++;
            if (ev_kind[mark] !== 1 || ev_data[mark] !== 8'hA5) begin
                errors++; $display("FAIL a5_data: got kind %0d data %h want valid A5", ev_kind[mark], ev_data[mark]);
            end
            lat = ev_cyc[mark] - tx_start_cyc;
            checks++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
                errors++; $display("FAIL a5_latency: got %0d clks want %0d..%0d", lat, LAT_MIN, LAT_MAX);
            end
        end
        last_good = 8'hA5;
    endtask

    task automatic test_glitch();
        int mark;
        mark = ev_kind.size();
        i_rx = 1'b0;
        wait_clks(3 * DIVV);
        i_rx = 1'b1;
        wait_clks(BIT);
        checks++;
        if (ev_kind.size() != mark) begin errors++; $display("FAIL glitch_pulse: got %0d events want 0", ev_kind.size() - mark); end
        checks++;
        if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL glitch_state: got %0d want IDLE", dut.state_q); end
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != 1 || ev_kind[ev_kind.size()-1] !== 1 || ev_data[ev_data.size()-1] !== 8'h3C) begin
            errors++; $display("FAIL glitch_next: got %0d events, last data %h want 1 valid 3C",
                               ev_kind.size() - mark, o_data);
        end
        last_good = 8'h3C;
    endtask

    task automatic test_frame_err();
        int mark;
        mark = ev_kind.size();
        send_frame(8'h5A, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != 2) begin
            errors++; $display("FAIL ferr_count: got %0d events want 2", ev_kind.size() - mark);
        end else begin
            checks++;
            if (ev_kind[mark] !== 2 || ev_data[mark] !== last_good) begin
                errors++; $display("FAIL ferr_first: got kind %0d data %h want err data %h",
                                   ev_kind[mark], ev_data[mark], last_good);
            end
            checks++;
            if (ev_kind[mark+1] !== 1 || ev_data[mark+1] !== 8'h81) begin
                errors++; $display("FAIL ferr_recover: got kind %0d data %h want valid 81",
                                   ev_kind[mark+1], ev_data[mark+1]);
            end
        end
        last_good = 8'h81;
    endtask

    task automatic test_back_to_back();
        int mark;
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h55;
        mark = ev_kind.size();
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1, 1'b0);
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != 3) begin
            errors++; $display("FAIL b2b_count: got %0d events want 3", ev_kind.size() - mark);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ev_kind[mark+i] !== 1 || ev_data[mark+i] !== exp_d[i]) begin
                    errors++; $display("FAIL b2b_%0d: got kind %0d data %h want valid %h",
                                       i, ev_kind[mark+i], ev_data[mark+i], exp_d[i]);
                end
            end
        end
        last_good = 8'h55;
    endtask

    task automatic test_reset_abort();
        int mark;
        logic [7:0] d;
        d = 8'h6B;
        mark = ev_kind.size();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        i_rx = d[4];
        wait_clks(BIT / 2);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        wait_clks(2);
        checks++;
        if (o_data !== 8'h00 || o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            errors++; $display("FAIL abort_in_reset: got data %h v=%b e=%b want 00 0 0", o_data, o_valid, o_frame_err);
        end
        wait_clks(BIT);
        i_rst = 1'b0;
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() != mark) begin errors++; $display("FAIL abort_pulse: got %0d events want 0", ev_kind.size() - mark); end
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != 1 || ev_kind[ev_kind.size()-1] !== 1 || ev_data[ev_data.size()-1] !== 8'hC3) begin
            errors++; $display("FAIL abort_next: got %0d events, o_data %h want 1 valid C3", ev_kind.size() - mark, o_data);
        end
        last_good = 8'hC3;
    endtask

    task automatic test_majority();
        int mark;
        mark = ev_kind.size();
        send_frame(8'h96, 1'b1, 1'b1);
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != 1 || ev_kind[ev_kind.size()-1] !== 1 || ev_data[ev_data.size()-1] !== 8'h96) begin
            errors++; $display("FAIL vote_96: got %0d events, o_data %h want 1 valid 96", ev_kind.size() - mark, o_data);
        end
        last_good = 8'h96;
    endtask

    // Random frames, some with a low stop bit; model = ordered list of
    // expected events, an error event carrying the last good payload.
    task automatic test_random();
        int         mark;
        int         exp_k[$];
        logic [7:0] exp_d[$];
        logic [7:0] d;
        logic       bad;
        int         gap;
        mark = ev_kind.size();
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            if (bad) begin
                exp_k.push_back(2);
                exp_d.push_back(last_good);
                gap = BIT * $urandom_range(1, 3);
            end else begin
                last_good = d;
                exp_k.push_back(1);
                exp_d.push_back(d);
                gap = BIT * $urandom_range(0, 2);
            end
            if (gap > 0) gap += $urandom_range(0, 3 * DIVV);
            send_frame(d, !bad, 1'b0);
            wait_clks(gap);
        end
        wait_clks(2 * BIT);
        checks++;
        if (ev_kind.size() - mark != exp_k.size()) begin
            errors++; $display("FAIL rand_count: got %0d events want %0d", ev_kind.size() - mark, exp_k.size());
        end else begin
            for (int i = 0; i < exp_k.size(); i++) begin
                checks++;
                if (ev_kind[mark+i] !== exp_k[i] || ev_data[mark+i] !== exp_d[i]) begin
                    errors++; $display("FAIL rand_%0d: got kind %0d data %h want kind %0d data %h",
                                       i, ev_kind[mark+i], ev_data[mark+i], exp_k[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles want 0", both_cnt); end
        checks++;
        if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_abort();
        test_majority();
        test_random();
        test_pulse_shape();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the i_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate in bit/s.
REQ-003 The block SHALL have parameter PAYLOAD_SIZE, default 8, meaning the number of data bits per frame.
REQ-004 The block SHALL have parameter OVERSAMPLE, default 16, meaning the number of sample ticks per bit (even, ≥ 8).
REQ-005 The block SHALL have port i_clk, input, width 1, meaning the single system clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port i_rst, input, width 1, meaning reset; it SHALL be asynchronous and active-high.
REQ-007 The block SHALL have port i_rx, input, width 1, meaning the asynchronous serial line, idle high.
REQ-008 The block SHALL have port o_data, output, width PAYLOAD_SIZE, meaning the last correctly received payload, LSB first on the wire.
REQ-009 The block SHALL have port o_valid, output, width 1, meaning a one-cycle pulse marking a new o_data.
REQ-010 The block SHALL have port o_frame_err, output, width 1, meaning a one-cycle pulse marking a frame whose stop bit was sampled low.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all references to "line" below mean the synchronized signal.
REQ-012 The tick generator SHALL use DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer floor; defaults give DIV = 325.
REQ-013 The tick counter SHALL be free-running, counting 0..DIV-1, and SHALL pulse tick for one clock when count = DIV-1, then wrap to 0.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE; all state changes SHALL occur only on tick clocks, except reset.
REQ-015 In IDLE, a line low on a tick SHALL move the FSM to START and clear the sample counter.
REQ-016 In START, at sample count OVERSAMPLE/2-1 the line SHALL be checked: if low, go to DATA with the sample counter cleared; if high (glitch), return to IDLE with no output pulse.
REQ-017 In DATA, each bit SHALL be decided by majority vote of the samples at counts OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2, relative to the bit centre aligned in START.
REQ-018 Each decided bit SHALL be shifted in LSB first; after PAYLOAD_SIZE bits the FSM SHALL go to STOP.
REQ-019 The bit counter SHALL be sized $clog2(PAYLOAD_SIZE+1) and SHALL never wrap within a frame.
REQ-020 In STOP, at the stop-bit centre, a majority-high vote SHALL load o_data from the shift register, pulse o_valid for exactly one clock (the clock after that tick), and return to IDLE.
REQ-021 In STOP, a majority-low vote SHALL pulse o_frame_err for one clock, leave o_data unchanged, and go to WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL return to IDLE only after the line has been high on one full bit of ticks (OVERSAMPLE consecutive ticks); this covers break conditions.
REQ-023 o_valid and o_frame_err SHALL never be asserted in the same cycle.
REQ-024 A new start bit SHALL be accepted from the tick after the stop-bit decision, so back-to-back frames with a single stop bit are received without loss.
REQ-025 No back-pressure SHALL exist: the consumer must capture o_data on o_valid, and o_data SHALL hold until the next valid frame.

Reset
REQ-026 While i_rst is high, the block SHALL force state IDLE, all counters 0, shift register 0, synchronizer 1, o_data 0, o_valid 0, o_frame_err 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame and produce no o_valid or o_frame_err pulse.
REQ-028 After reset deasserts, reception SHALL resume from IDLE at the first falling edge.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (3-bit localparams) and the DIV computation function, so the same DIV is used by uart_tx.
REQ-030 The tick generator SHALL be a separate sub-module named baud_tick_gen (parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE; outputs tick); the synchronizer, FSM and shift register SHALL be in uart_rx.

Verification
REQ-031 The bench SHALL send frame 0xA5 at 9600 baud -> exactly one o_valid pulse with o_data = 0xA5, about 9.5 bit times after the start edge; o_frame_err stays 0.
REQ-032 The bench SHALL drive a 3-tick low glitch on the idle line -> no o_valid or o_frame_err pulse; the FSM is back in IDLE, and the following 0x3C frame is received correctly.
REQ-033 The bench SHALL send 0x5A with the stop bit held low, then the line high for 1 bit time, then 0x81 -> first an o_frame_err pulse with o_data unchanged, then o_valid with o_data = 0x81.
REQ-034 The bench SHALL send 0x00, 0xFF, 0x55 back-to-back with one stop bit each -> three o_valid pulses with those values, in order.
REQ-035 The bench SHALL assert i_rst during data bit 4 of a frame, then release it and send 0xC3 -> outputs are 0 during reset, no pulse for the aborted frame, then o_valid with o_data = 0xC3.
REQ-036 The bench SHALL inject a single-sample flip at the centre of each data bit of 0x96 -> the majority vote yields o_data = 0x96.
